// File: rtl/card_sprite_renderer_pkg.sv
// Shared types, geometry constants and the per-axis step helper for the
// card sprite renderer. Optional feature macro: CARD_BLINK_EN.
package card_pkg;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 32;
  localparam int SCREEN_W = 256;
  localparam int SCREEN_H = 240;

  typedef logic [2:0] color_t;
  typedef logic [7:0] pos_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    DONE
  } mover_state_t;

  // Move one axis toward its target by at most step; lands exactly on the target.
  function automatic pos_t step_toward(pos_t cur, pos_t tgt, pos_t step);
    if (cur < tgt) begin
      return ((tgt - cur) <= step) ? tgt : pos_t'(cur + step);
    end else if (cur > tgt) begin
      return ((cur - tgt) <= step) ? tgt : pos_t'(cur - step);
    end
    return cur;
  endfunction

endpackage

// File: rtl/card_sprite_renderer_if.sv
// Pixel, move-control and sprite-RAM signals of the card sprite renderer.
// slave: the renderer; master: whoever drives pixels, moves and the RAM.
interface card_sprite_renderer_if;
  import card_pkg::*;

  pos_t       pix_x;
  pos_t       pix_y;
  logic       pix_en;
  logic       frame_start;
  logic       move_req;
  pos_t       tgt_x;
  pos_t       tgt_y;
  logic       move_busy;
  logic       move_done;
  logic [8:0] rAddr;
  logic       RE;
  color_t     dataIn;
  color_t     pix_color;
  logic       pix_valid;

  modport slave (
    input  pix_x, pix_y, pix_en, frame_start, move_req, tgt_x, tgt_y, dataIn,
    output move_busy, move_done, rAddr, RE, pix_color, pix_valid
  );

  modport master (
    output pix_x, pix_y, pix_en, frame_start, move_req, tgt_x, tgt_y, dataIn,
    input  move_busy, move_done, rAddr, RE, pix_color, pix_valid
  );
endinterface

// File: rtl/card_sprite_renderer_mover.sv
// card_mover: frame-synchronous move FSM owning the card position.
// With CARD_BLINK_EN a frame counter hides the card every other
// BLINK_FRAMES-long period while moving.
module card_mover
  import card_pkg::*;
#(
  parameter pos_t INIT_X       = 8'd0,
  parameter pos_t INIT_Y       = 8'd0,
  parameter int   STEP         = 4,
  parameter int   BLINK_FRAMES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_start_i,
  input  logic move_req_i,
  input  pos_t tgt_x_i,
  input  pos_t tgt_y_i,
  output pos_t cur_x_o,
  output pos_t cur_y_o,
  output logic move_busy_o,
  output logic move_done_o,
  output logic hide_o
);

  mover_state_t state_q, state_d;
  pos_t cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  pos_t tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  pos_t step_x, step_y;

  assign step_x = step_toward(cur_x_q, tgt_x_q, pos_t'(STEP));
  assign step_y = step_toward(cur_y_q, tgt_y_q, pos_t'(STEP));

  // Next-state logic: latch target in IDLE, step once per frame in MOVING.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    tgt_x_d = tgt_x_q;
    tgt_y_d = tgt_y_q;
    case (state_q)
      IDLE: begin
        if (move_req_i) begin
          tgt_x_d = tgt_x_i;
          tgt_y_d = tgt_y_i;
          state_d = MOVING;
        end
      end
      MOVING: begin
        if (frame_start_i) begin
          cur_x_d = step_x;
          cur_y_d = step_y;
          if (step_x == tgt_x_q && step_y == tgt_y_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, position and target registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      cur_x_q <= INIT_X;
      cur_y_q <= INIT_Y;
      tgt_x_q <= INIT_X;
      tgt_y_q <= INIT_Y;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      tgt_x_q <= tgt_x_d;
      tgt_y_q <= tgt_y_d;
    end
  end

  assign cur_x_o     = cur_x_q;
  assign cur_y_o     = cur_y_q;
  assign move_busy_o = (state_q == MOVING);
  assign move_done_o = (state_q == DONE);

`ifdef CARD_BLINK_EN
  localparam int BW = $clog2(2 * BLINK_FRAMES);
  logic [BW-1:0] blink_q, blink_d;

  // Frame counter modulo two blink half-periods; cleared on leaving MOVING.
  always_comb begin
    blink_d = blink_q;
    if (state_q == MOVING && state_d != MOVING) begin
      blink_d = '0;
    end else if (state_q == MOVING && frame_start_i) begin
      blink_d = (blink_q == BW'(2 * BLINK_FRAMES - 1)) ? '0 : blink_q + 1'b1;
    end
  end

  // Blink counter register.
  always_ff @(posedge clock) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_d;
  end

  assign hide_o = (blink_q >= BW'(BLINK_FRAMES));
`else
  // Card is always visible; BLINK_FRAMES is only referenced so it stays a live parameter.
  assign hide_o = (BLINK_FRAMES < 1);
`endif

endmodule

// File: rtl/card_sprite_renderer.sv
// card_sprite_renderer: hit test of the pixel position against the card,
// sprite RAM addressing and a 3-edge pixel pipeline (RAM read is registered).
// Optional feature macro: CARD_BLINK_EN (blink while moving).
module card_sprite_renderer
  import card_pkg::*;
#(
  parameter pos_t   INIT_X       = 8'd0,
  parameter pos_t   INIT_Y       = 8'd0,
  parameter int     STEP         = 4,
  parameter color_t TRANSP       = 3'b000,
  parameter int     BLINK_FRAMES = 8
) (
  input  logic clock,
  input  logic reset,
  card_sprite_renderer_if.slave bus
);

  pos_t       cur_x, cur_y;
  logic       hide;
  logic [8:0] x_end, y_end;
  logic       hit;
  logic [3:0] col;
  logic [4:0] row;
  logic       valid_next;

  logic [8:0] raddr_q;
  logic       hit1_q, hit2_q;
  logic       valid_q;
  color_t     color_q;

  card_mover #(
    .INIT_X       (INIT_X),
    .INIT_Y       (INIT_Y),
    .STEP         (STEP),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_mover (
    .clock         (clock),
    .reset         (reset),
    .frame_start_i (bus.frame_start),
    .move_req_i    (bus.move_req),
    .tgt_x_i       (bus.tgt_x),
    .tgt_y_i       (bus.tgt_y),
    .cur_x_o       (cur_x),
    .cur_y_o       (cur_y),
    .move_busy_o   (bus.move_busy),
    .move_done_o   (bus.move_done),
    .hide_o        (hide)
  );

  // 9-bit end coordinates clip a card near the right/bottom edge instead of wrapping.
  assign x_end = {1'b0, cur_x} + 9'(SPRITE_W);
  assign y_end = {1'b0, cur_y} + 9'(SPRITE_H);

  assign hit = bus.pix_en && !hide
            && bus.pix_x >= cur_x && {1'b0, bus.pix_x} < x_end
            && {1'b0, bus.pix_x} < 9'(SCREEN_W)
            && bus.pix_y >= cur_y && {1'b0, bus.pix_y} < y_end
            && bus.pix_y < 8'(SCREEN_H);

  assign col = 4'(bus.pix_x - cur_x);
  assign row = 5'(bus.pix_y - cur_y);

  assign valid_next = hit2_q && (bus.dataIn != TRANSP);

  // Pixel pipeline: address on edge 1, RAM data on edge 2, colour on edge 3.
  always_ff @(posedge clock) begin
    if (reset) begin
      raddr_q <= '0;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      valid_q <= 1'b0;
      color_q <= '0;
    end else begin
      if (hit) raddr_q <= {row, col};
      hit1_q  <= hit;
      hit2_q  <= hit1_q;
      valid_q <= valid_next;
      color_q <= valid_next ? bus.dataIn : 3'b000;
    end
  end

  assign bus.rAddr     = raddr_q;
  assign bus.RE        = hit1_q;
  assign bus.pix_valid = valid_q;
  assign bus.pix_color = color_q;

endmodule

// File: tb/tb_card_sprite_renderer.sv
// Directed bench for card_sprite_renderer: table of single-pixel vectors
// on two instances plus hand-written move, blink and reset sequences.
module tb_card_sprite_renderer;
  import card_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  int   done_cnt = 0;

  logic [2:0] ram [512];

  card_sprite_renderer_if bus_a ();
  card_sprite_renderer_if bus_b ();

  card_sprite_renderer #(
    .INIT_X(8'd40), .INIT_Y(8'd100), .STEP(4), .TRANSP(3'b000), .BLINK_FRAMES(2)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  card_sprite_renderer #(
    .INIT_X(8'd250), .INIT_Y(8'd230), .STEP(4), .TRANSP(3'b000), .BLINK_FRAMES(2)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clock = ~clock;

  // Registered-read sprite RAM models.
  always @(posedge clock) begin
    if (reset)          bus_a.dataIn <= 3'b000;
    else if (bus_a.RE)  bus_a.dataIn <= ram[bus_a.rAddr];
    if (reset)          bus_b.dataIn <= 3'b000;
    else if (bus_b.RE)  bus_b.dataIn <= ram[bus_b.rAddr];
  end

  always @(negedge clock) if (bus_a.move_done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pix(input bit sel_b, input logic [7:0] x, input logic [7:0] y, input logic en);
    bus_a.pix_en = 1'b0;
    bus_b.pix_en = 1'b0;
    if (sel_b) begin
      bus_b.pix_x = x; bus_b.pix_y = y; bus_b.pix_en = en;
    end else begin
      bus_a.pix_x = x; bus_a.pix_y = y; bus_a.pix_en = en;
    end
  endtask

  typedef struct {
    bit         sel_b;
    logic [7:0] x;
    logic [7:0] y;
    logic       en;
    logic       exp_re;
    logic [8:0] exp_addr;
    logic       exp_valid;
    logic [2:0] exp_color;
  } vec_t;

  vec_t vecs [13];

  task automatic run_vec(input vec_t v, input int idx);
    logic       re, valid;
    logic [8:0] addr;
    logic [2:0] color;
    set_pix(v.sel_b, v.x, v.y, v.en);
    tick();
    re   = v.sel_b ? bus_b.RE : bus_a.RE;
    addr = v.sel_b ? bus_b.rAddr : bus_a.rAddr;
    check($sformatf("vec%0d RE", idx), 32'(re), 32'(v.exp_re));
    if (v.exp_re) check($sformatf("vec%0d rAddr", idx), 32'(addr), 32'(v.exp_addr));
    set_pix(v.sel_b, v.x, v.y, 1'b0);
    tick();
    valid = v.sel_b ? bus_b.pix_valid : bus_a.pix_valid;
    check($sformatf("vec%0d early valid", idx), 32'(valid), 32'(0));
    tick();
    valid = v.sel_b ? bus_b.pix_valid : bus_a.pix_valid;
    color = v.sel_b ? bus_b.pix_color : bus_a.pix_color;
    check($sformatf("vec%0d pix_valid", idx), 32'(valid), 32'(v.exp_valid));
    check($sformatf("vec%0d pix_color", idx), 32'(color), 32'(v.exp_color));
    tick();
  endtask

  // Card at (x,y) on dut_a: origin pixel hits at address 0 when visible, left neighbour never hits.
  task automatic probe(input logic [7:0] x, input logic [7:0] y, input bit vis, input string tag);
    set_pix(1'b0, x, y, 1'b1);
    tick();
    check({tag, " RE"}, 32'(bus_a.RE), 32'(vis));
    if (vis) check({tag, " rAddr"}, 32'(bus_a.rAddr), 32'(0));
    set_pix(1'b0, x - 8'd1, y, 1'b1);
    tick();
    check({tag, " left RE"}, 32'(bus_a.RE), 32'(0));
    set_pix(1'b0, x, y, 1'b0);
  endtask

  task automatic frame();
    bus_a.frame_start = 1'b1;
    tick();
    bus_a.frame_start = 1'b0;
  endtask

  task automatic request(input logic [7:0] x, input logic [7:0] y, input bit with_frame);
    bus_a.move_req = 1'b1;
    bus_a.tgt_x = x;
    bus_a.tgt_y = y;
    bus_a.frame_start = with_frame;
    tick();
    bus_a.move_req = 1'b0;
    bus_a.frame_start = 1'b0;
  endtask

  initial begin
    int  dc;
    bit  vis;
    for (int i = 0; i < 512; i++) ram[i] = 3'b010;
    ram[0]   = 3'b101;
    ram[1]   = 3'b000;
    ram[5]   = 3'b110;
    ram[55]  = 3'b011;
    ram[511] = 3'b111;

    vecs[0]  = '{1'b0, 8'd40,  8'd100, 1'b1, 1'b1, 9'h000, 1'b1, 3'b101};
    vecs[1]  = '{1'b0, 8'd55,  8'd131, 1'b1, 1'b1, 9'h1FF, 1'b1, 3'b111};
    vecs[2]  = '{1'b0, 8'd56,  8'd100, 1'b1, 1'b0, 9'h000, 1'b0, 3'b000};
    vecs[3]  = '{1'b0, 8'd40,  8'd132, 1'b1, 1'b0, 9'h000, 1'b0, 3'b000};
    vecs[4]  = '{1'b0, 8'd41,  8'd100, 1'b1, 1'b1, 9'h001, 1'b0, 3'b000};
    vecs[5]  = '{1'b0, 8'd47,  8'd103, 1'b1, 1'b1, 9'h037, 1'b1, 3'b011};
    vecs[6]  = '{1'b0, 8'd40,  8'd100, 1'b0, 1'b0, 9'h000, 1'b0, 3'b000};
    vecs[7]  = '{1'b0, 8'd39,  8'd100, 1'b1, 1'b0, 9'h000, 1'b0, 3'b000};
    vecs[8]  = '{1'b1, 8'd255, 8'd230, 1'b1, 1'b1, 9'h005, 1'b1, 3'b110};
    vecs[9]  = '{1'b1, 8'd255, 8'd239, 1'b1, 1'b1, 9'h095, 1'b1, 3'b010};
    vecs[10] = '{1'b1, 8'd255, 8'd240, 1'b1, 1'b0, 9'h000, 1'b0, 3'b000};
    vecs[11] = '{1'b1, 8'd4,   8'd230, 1'b1, 1'b0, 9'h000, 1'b0, 3'b000};
    vecs[12] = '{1'b1, 8'd250, 8'd229, 1'b1, 1'b0, 9'h000, 1'b0, 3'b000};

    reset = 1'b1;
    set_pix(1'b0, 8'd0, 8'd0, 1'b0);
    bus_a.frame_start = 1'b0; bus_a.move_req = 1'b0; bus_a.tgt_x = 8'd0; bus_a.tgt_y = 8'd0;
    bus_b.frame_start = 1'b0; bus_b.move_req = 1'b0; bus_b.tgt_x = 8'd0; bus_b.tgt_y = 8'd0;
    bus_b.pix_x = 8'd0; bus_b.pix_y = 8'd0;
    repeat (3) tick();
    check("reset RE", 32'(bus_a.RE), 32'(0));
    check("reset rAddr", 32'(bus_a.rAddr), 32'(0));
    check("reset pix_valid", 32'(bus_a.pix_valid), 32'(0));
    check("reset pix_color", 32'(bus_a.pix_color), 32'(0));
    check("reset move_busy", 32'(bus_a.move_busy), 32'(0));
    check("reset move_done", 32'(bus_a.move_done), 32'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Move (40,100) -> (50,100): 44, 48, 50; a second request mid-move is ignored.
    check("idle busy", 32'(bus_a.move_busy), 32'(0));
    request(8'd50, 8'd100, 1'b0);
    check("move busy after req", 32'(bus_a.move_busy), 32'(1));
    check("move done after req", 32'(bus_a.move_done), 32'(0));
    frame();
    check("move busy f1", 32'(bus_a.move_busy), 32'(1));
    probe(8'd44, 8'd100, 1'b1, "pos f1");
    request(8'd10, 8'd10, 1'b0);
    frame();
    probe(8'd48, 8'd100, 1'b1, "pos f2");
    frame();
    check("move done f3", 32'(bus_a.move_done), 32'(1));
    check("move busy f3", 32'(bus_a.move_busy), 32'(0));
    tick();
    check("move done cleared", 32'(bus_a.move_done), 32'(0));
    check("move busy idle", 32'(bus_a.move_busy), 32'(0));
    probe(8'd50, 8'd100, 1'b1, "pos final");
    check("done pulses move1", 32'(done_cnt), 32'(1));

    // Request together with frame_start: latch only, step on the next frame.
    request(8'd46, 8'd100, 1'b1);
    check("coincident busy", 32'(bus_a.move_busy), 32'(1));
    probe(8'd50, 8'd100, 1'b1, "coincident no step");
    frame();
    check("coincident done", 32'(bus_a.move_done), 32'(1));
    tick();
    probe(8'd46, 8'd100, 1'b1, "coincident pos");

    // Target equal to current position still passes MOVING -> DONE on a frame.
    request(8'd46, 8'd100, 1'b0);
    check("same-target busy", 32'(bus_a.move_busy), 32'(1));
    frame();
    check("same-target done", 32'(bus_a.move_done), 32'(1));
    tick();
    probe(8'd46, 8'd100, 1'b1, "same-target pos");
    check("done pulses total", 32'(done_cnt), 32'(3));

    // Long move: visibility per frame, then reset abandons it.
    request(8'd100, 8'd100, 1'b0);
    for (int k = 0; k < 6; k++) begin
`ifdef CARD_BLINK_EN
      vis = ((k / 2) % 2) == 0;
`else
      vis = 1'b1;
`endif
      probe(8'(46 + 4 * k), 8'd100, vis, $sformatf("blink k%0d", k));
      frame();
    end
    check("long move busy", 32'(bus_a.move_busy), 32'(1));
    dc = done_cnt;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("mid-move reset busy", 32'(bus_a.move_busy), 32'(0));
    check("mid-move reset done", 32'(bus_a.move_done), 32'(0));
    probe(8'd40, 8'd100, 1'b1, "reset pos");
    frame();
    tick();
    check("post-reset busy", 32'(bus_a.move_busy), 32'(0));
    check("no done after reset", 32'(done_cnt), 32'(dc));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
